led_pattern_ctrl: RTL and testbench
===================================

# led_pattern_ctrl

Controller that sequences the board's 4-LED bank through selectable patterns at a selectable rate. It replaces a fixed free-running rotator. It sits between the debounced key pulses and the LED pins: it owns the tick prescaler, the pattern state machine and the `light` register. Rotation direction, blink, bounce, speed and pause are all runtime-controlled.

## Interface
- `TICK_MAX`, default 25'd24999999: prescaler terminal count at speed 0 (0.5 s at 50 MHz). Must fit in 25 bits.
- `clk50m`  in  1  system clock, 50 MHz.
- `rst`  in  1  **synchronous, active-high reset.**
- `mode_next`  in  1  single-cycle pulse (already debounced): advance to the next mode.
- `speed_up`  in  1  single-cycle pulse (already debounced): advance to the next speed level.
- `pause`  in  1  level: while high, the pattern freezes.
- `light`  out  4  LED drive, active-low (0 = lit), registered.
- `mode`  out  2  current mode, registered.
- `speed`  out  2  current speed level, registered.
- `tick`  out  1  registered pulse, high for exactly the one cycle in which `light` shows a newly advanced step.

## Operation
- Modes:
  - 0 ROT_R: `light <= {light[0], light[3:1]}`.
  - 1 ROT_L: `light <= {light[2:0], light[3]}`.
  - 2 BLINK: `light <= ~light`.
  - 3 BOUNCE: the single lit (0) bit walks 0111→1011→1101→1110→1101→1011→0111→… The direction reverses at each end, and no end position is repeated.
- Seed pattern on entering a mode: 4'b0111 for ROT_R, ROT_L and BOUNCE; 4'b1111 for BLINK. BOUNCE always starts moving toward bit 0.
- Speed levels 0..3: `limit = TICK_MAX >> speed`.
- Prescaler:
  - 25-bit `cnt`, cleared to 0 at reset.
  - A step occurs on a cycle where `cnt >= limit`, `pause` = 0, and neither `mode_next` nor `speed_up` is asserted.
  - On a step, `cnt` returns to 0; otherwise `cnt` increments.
  - Step period is `limit + 1` cycles. The `>=` comparison guarantees a step on the next eligible cycle after a speed increase shrinks `limit` below `cnt`.
- `mode_next`:
  - `mode <= mode + 1` (wraps 3→0).
  - `light` loads the new mode's seed; `cnt <= 0`; BOUNCE direction is reset.
  - No step and no `tick` that cycle.
- `speed_up`:
  - `speed <= speed + 1` (wraps 3→0); `cnt <= 0`.
  - `light` is unchanged; no step that cycle.
- Simultaneous `mode_next` and `speed_up`: both take effect; `cnt <= 0`.
- `pause` high: `cnt`, `light` and direction hold, and `tick` stays 0. `mode_next` and `speed_up` are still honored while paused (seed load, counter clear).
- Reset (`rst` = 1 at a `clk50m` edge, overriding all other inputs): `light` = 4'b0111, `mode` = 0, `speed` = 0, `cnt` = 0, `tick` = 0, BOUNCE direction = toward bit 0. Reset mid-pattern abandons the current step immediately.

## Timing
- All outputs change only on the rising edge of `clk50m`. No combinational input-to-output paths.
- Step latency: `light` and `tick` update on the edge that ends the cycle in which `cnt == limit`. The first step after reset or a control pulse occurs `limit + 1` cycles later.
- `mode_next` / `speed_up`: the new `mode`, `speed` and seed are visible on the edge that samples the pulse (1-cycle latency).
- Pulses wider than one cycle are treated as repeated events, one per cycle. The upstream debouncer guarantees single-cycle pulses.
- Releasing `pause` resumes counting from the held `cnt`. No immediate step unless `cnt >= limit`.

## Test plan
- **Reset and ROT_R** (`TICK_MAX` = 7): release `rst` → `light` 0111; `tick` fires every 8 cycles; `light` sequence 1011, 1101, 1110, 0111.
- **Speed stepping:** pulse `speed_up` three times, with `cnt` at 5 before the first pulse. Required periods: 4, then 2, then 1 cycle. A fourth pulse wraps `speed` to 0 (period 8). `light` is unchanged by each pulse.
- **Mode sequencing:**
  - Pulse `mode_next` → `mode` 1, `light` 0111, `tick` 0 that cycle; then 1110, 1101 on successive ticks.
  - Next pulse → BLINK: 1111, 0000, 1111.
  - Next pulse → BOUNCE: 0111, 1011, 1101, 1110, 1101, 1011, 0111, 1011.
- **Pause:** assert `pause` for 20 cycles mid-period with `cnt` = 3 → `light` and `tick` frozen. After release, the next tick comes exactly 5 cycles later.
- **Collisions:**
  - `mode_next` on the same cycle `cnt == limit` → seed loaded, no step, next tick after 8 cycles.
  - `mode_next` and `speed_up` together → `mode` +1, `speed` +1, `cnt` 0.
- **Reset mid-operation:** BOUNCE moving toward bit 3, `speed` 2, paused; assert `rst` for one cycle → all outputs at reset values. Then ROT_R resumes with 8-cycle period.

Source files
------------

// File: rtl/led_pattern_ctrl_if.sv
// Control and LED signal bundle for led_pattern_ctrl.
// master: key-pulse / pause source. slave: the pattern controller.
interface led_pattern_ctrl_if;
   logic       mode_next;
   logic       speed_up;
   logic       pause;
   logic [3:0] light;
   logic [1:0] mode;
   logic [1:0] speed;
   logic       tick;

   modport master (
      output mode_next, speed_up, pause,
      input  light, mode, speed, tick
   );

   modport slave (
      input  mode_next, speed_up, pause,
      output light, mode, speed, tick
   );
endinterface

// File: rtl/led_pattern_ctrl.sv
// 4-LED pattern sequencer: tick prescaler with selectable speed, pattern state
// machine (rotate right/left, blink, bounce) and active-low LED register.
module led_pattern_ctrl #(
   parameter logic [24:0] TICK_MAX = 25'd24999999
) (
   input  logic              clk50m,
   input  logic              rst,
   led_pattern_ctrl_if.slave ctrl
);

   typedef enum logic [1:0] {
      ModeRotR   = 2'd0,
      ModeRotL   = 2'd1,
      ModeBlink  = 2'd2,
      ModeBounce = 2'd3
   } mode_e;

   mode_e       mode_q;
   logic [1:0]  speed_q;
   logic [24:0] cnt_q;
   logic [3:0]  light_q;
   logic        tick_q;
   logic        dir_up_q;   // bounce: 1 = lit bit moving toward bit 3

   mode_e       mode_inc;
   logic [24:0] limit;
   logic        ctrl_evt;
   logic        step;
   logic [3:0]  seed;
   logic        bounce_at_end;
   logic        bounce_up;
   logic [3:0]  step_light;

   assign limit    = TICK_MAX >> speed_q;
   assign ctrl_evt = ctrl.mode_next | ctrl.speed_up;
   // Control pulses and pause both suppress the step for that cycle.
   assign step     = (cnt_q >= limit) & ~ctrl.pause & ~ctrl_evt;

   // Next mode, its seed, and the pattern one step ahead of the current one.
   always_comb begin
      mode_inc      = mode_e'(mode_q + 2'd1);
      seed          = (mode_inc == ModeBlink) ? 4'b1111 : 4'b0111;
      bounce_at_end = dir_up_q ? ~light_q[3] : ~light_q[0];
      bounce_up     = dir_up_q ^ bounce_at_end;
      step_light    = light_q;
      unique case (mode_q)
         ModeRotR:   step_light = {light_q[0], light_q[3:1]};
         ModeRotL:   step_light = {light_q[2:0], light_q[3]};
         ModeBlink:  step_light = ~light_q;
         ModeBounce: step_light = bounce_up ? {light_q[2:0], 1'b1} : {1'b1, light_q[3:1]};
         default:    step_light = light_q;
      endcase
   end

   // Prescaler, mode/speed selection and pattern register.
   always_ff @(posedge clk50m) begin
      if (rst) begin
         mode_q   <= ModeRotR;
         speed_q  <= 2'd0;
         cnt_q    <= '0;
         light_q  <= 4'b0111;
         tick_q   <= 1'b0;
         dir_up_q <= 1'b0;
      end else begin
         tick_q <= step;
         if (ctrl_evt) begin
            cnt_q <= '0;
            if (ctrl.speed_up) begin
               speed_q <= speed_q + 2'd1;
            end
            if (ctrl.mode_next) begin
               mode_q   <= mode_inc;
               light_q  <= seed;
               dir_up_q <= 1'b0;
            end
         end else if (step) begin
            cnt_q   <= '0;
            light_q <= step_light;
            if (mode_q == ModeBounce) begin
               dir_up_q <= bounce_up;
            end
         end else if (!ctrl.pause) begin
            cnt_q <= cnt_q + 25'd1;
         end
      end
   end

   assign ctrl.light = light_q;
   assign ctrl.mode  = mode_q;
   assign ctrl.speed = speed_q;
   assign ctrl.tick  = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl with TICK_MAX = 7.
module tb_led_pattern_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   led_pattern_ctrl_if ctrl ();

   led_pattern_ctrl #(
      .TICK_MAX (25'd7)
   ) dut (
      .clk50m (clk),
      .rst    (rst),
      .ctrl   (ctrl)
   );

   always #10 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: each mode is a cyclic list of patterns; a step advances the index.
   logic [3:0] seq [4][6];
   int         seq_len [4];
   int         m_mode  = 0;
   int         m_speed = 0;
   int         m_phase = 0;
   int         m_idx   = 0;
   logic       m_tick  = 1'b0;

   typedef struct {
      logic       r, mn, su, pz;
      int         n;
      logic [3:0] light;
      logic [1:0] mode;
      logic [1:0] speed;
      logic       tick;
   } vec_t;
   vec_t vecs[$];

   logic r_r, r_mn, r_su, r_pz;

   function automatic logic [3:0] m_light();
      return seq[m_mode][m_idx];
   endfunction

   task automatic model_step(input logic r, mn, su, pz);
      if (r) begin
         m_mode = 0; m_speed = 0; m_phase = 0; m_idx = 0; m_tick = 1'b0;
      end else if (mn || su) begin
         if (su) m_speed = (m_speed + 1) % 4;
         if (mn) begin
            m_mode = (m_mode + 1) % 4;
            m_idx  = 0;
         end
         m_phase = 0;
         m_tick  = 1'b0;
      end else if (pz) begin
         m_tick = 1'b0;
      end else if (m_phase >= (7 >> m_speed)) begin
         m_idx   = (m_idx + 1) % seq_len[m_mode];
         m_phase = 0;
         m_tick  = 1'b1;
      end else begin
         m_phase++;
         m_tick = 1'b0;
      end
   endtask

   task automatic cycle(input logic r, mn, su, pz);
      @(negedge clk);
      rst            = r;
      ctrl.mode_next = mn;
      ctrl.speed_up  = su;
      ctrl.pause     = pz;
      @(posedge clk);
      model_step(r, mn, su, pz);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, mn, su, pz, input int n, input logic [3:0] l,
                      input logic [1:0] m, s, input logic t);
      vec_t v;
      v = '{r, mn, su, pz, n, l, m, s, t};
      vecs.push_back(v);
   endtask

   // Idle cycles until tick, bounded; the count is the period from the last event.
   task automatic period(input string name, input int exp);
      int c = 0;
      do begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0);
         c++;
      end while (ctrl.tick !== 1'b1 && c < 40);
      check(name, c, exp);
   endtask

   task automatic check_all(input string name, input logic [3:0] l, input logic [1:0] m,
                            input logic [1:0] s, input logic t);
      check({name, " light"}, ctrl.light, l);
      check({name, " mode"}, ctrl.mode, m);
      check({name, " speed"}, ctrl.speed, s);
      check({name, " tick"}, ctrl.tick, t);
   endtask

   initial begin
      ctrl.mode_next = 1'b0;
      ctrl.speed_up  = 1'b0;
      ctrl.pause     = 1'b0;

      seq[0] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0000, 4'b0000};
      seq[1] = '{4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0000, 4'b0000};
      seq[2] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      seq[3] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1101, 4'b1011};
      seq_len = '{4, 4, 2, 6};

      // Reset and ROT_R
      add(1, 0, 0, 0, 1, 4'b0111, 0, 0, 0);
      add(0, 0, 0, 0, 7, 4'b0111, 0, 0, 0);
      add(0, 0, 0, 0, 1, 4'b1011, 0, 0, 1);
      add(0, 0, 0, 0, 8, 4'b1101, 0, 0, 1);
      add(0, 0, 0, 0, 8, 4'b1110, 0, 0, 1);
      add(0, 0, 0, 0, 8, 4'b0111, 0, 0, 1);
      // ROT_L
      add(0, 1, 0, 0, 1, 4'b0111, 1, 0, 0);
      add(0, 0, 0, 0, 8, 4'b1110, 1, 0, 1);
      add(0, 0, 0, 0, 8, 4'b1101, 1, 0, 1);
      // BLINK
      add(0, 1, 0, 0, 1, 4'b1111, 2, 0, 0);
      add(0, 0, 0, 0, 8, 4'b0000, 2, 0, 1);
      add(0, 0, 0, 0, 8, 4'b1111, 2, 0, 1);
      // BOUNCE
      add(0, 1, 0, 0, 1, 4'b0111, 3, 0, 0);
      add(0, 0, 0, 0, 8, 4'b1011, 3, 0, 1);
      add(0, 0, 0, 0, 8, 4'b1101, 3, 0, 1);
      add(0, 0, 0, 0, 8, 4'b1110, 3, 0, 1);
      add(0, 0, 0, 0, 8, 4'b1101, 3, 0, 1);
      add(0, 0, 0, 0, 8, 4'b1011, 3, 0, 1);
      add(0, 0, 0, 0, 8, 4'b0111, 3, 0, 1);
      add(0, 0, 0, 0, 8, 4'b1011, 3, 0, 1);
      // Pause at cnt = 3, then resume: tick 5 cycles after release
      add(0, 0, 0, 0, 3, 4'b1011, 3, 0, 0);
      add(0, 0, 0, 1, 20, 4'b1011, 3, 0, 0);
      add(0, 0, 0, 0, 4, 4'b1011, 3, 0, 0);
      add(0, 0, 0, 0, 1, 4'b1101, 3, 0, 1);
      // mode_next exactly when cnt == limit
      add(0, 0, 0, 0, 7, 4'b1101, 3, 0, 0);
      add(0, 1, 0, 0, 1, 4'b0111, 0, 0, 0);
      add(0, 0, 0, 0, 7, 4'b0111, 0, 0, 0);
      add(0, 0, 0, 0, 1, 4'b1011, 0, 0, 1);
      // mode_next and speed_up together
      add(0, 1, 1, 0, 1, 4'b0111, 1, 1, 0);
      add(0, 0, 0, 0, 3, 4'b0111, 1, 1, 0);
      add(0, 0, 0, 0, 1, 4'b1110, 1, 1, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         for (int k = 0; k < vecs[i].n; k++) begin
            cycle(vecs[i].r, vecs[i].mn, vecs[i].su, vecs[i].pz);
         end
         check_all($sformatf("vec%0d", i), vecs[i].light, vecs[i].mode, vecs[i].speed,
                   vecs[i].tick);
      end

      // Speed stepping: cnt at 5 before first speed_up
      cycle(1, 0, 0, 0);
      repeat (5) cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 0);
      check_all("spd1 pulse", 4'b0111, 0, 1, 0);
      period("spd1 period a", 4);
      period("spd1 period b", 4);
      cycle(0, 0, 1, 0);
      check_all("spd2 pulse", 4'b1101, 0, 2, 0);
      period("spd2 period a", 2);
      period("spd2 period b", 2);
      cycle(0, 0, 1, 0);
      check_all("spd3 pulse", 4'b0111, 0, 3, 0);
      period("spd3 period a", 1);
      period("spd3 period b", 1);
      cycle(0, 0, 1, 0);
      check_all("spd0 pulse", 4'b1101, 0, 0, 0);
      period("spd0 period", 8);
      check("spd0 light", ctrl.light, 4'b1110);

      // Reset while bouncing toward bit 3, speed 2, paused
      cycle(1, 0, 0, 0);
      repeat (3) cycle(0, 1, 0, 0);
      repeat (2) cycle(0, 0, 1, 0);
      repeat (8) cycle(0, 0, 0, 0);
      check_all("bounce up", 4'b1101, 3, 2, 1);
      repeat (3) cycle(0, 0, 0, 1);
      check_all("bounce paused", 4'b1101, 3, 2, 0);
      cycle(1, 0, 0, 1);
      check_all("mid reset", 4'b0111, 0, 0, 0);
      period("post reset period", 8);
      check("post reset light", ctrl.light, 4'b1011);

      // Random stimulus against the model
      r_pz = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) r_pz = ~r_pz;
         r_r  = ($urandom_range(0, 199) == 0);
         r_mn = ($urandom_range(0, 19) == 0);
         r_su = ($urandom_range(0, 24) == 0);
         cycle(r_r, r_mn, r_su, r_pz);
         check_all($sformatf("rnd%0d", i), m_light(), 2'(m_mode), 2'(m_speed), m_tick);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
